key_ctrl: RTL and testbench
===========================

# key_ctrl

Memory-mapped controller for the board's 8 push-buttons, sitting behind the system bridge alongside the other peripherals. It synchronises the raw active-low key pins, debounces each key on a shared sample tick, latches press events into a pending register, and raises a maskable interrupt to the CPU's external interrupt input. Software reads debounced state and pending events and acknowledges events through the same register window.

## Interface
- N_KEYS, 8, number of keys (1..32)
- TICK_DIV, 50000, clock cycles per debounce sample tick (>=2)
- DEB_SAMPLES, 4, consecutive equal tick samples needed to accept a new key level (>=1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- key_in  in  N_KEYS  raw key pins, active-low (0 = pressed), asynchronous to clk
- addr  in  2  word select (byte address bits [3:2])
- we  in  1  write strobe, one cycle per access
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- irq  out  1  interrupt request, level, active-high

## Operation
- Synchroniser: 2-flop chain per key, inverted to active-high at its output (sync).
- Tick: free-running counter 0..TICK_DIV-1; tick pulse in the cycle the counter equals TICK_DIV-1; counter restarts at 0 after reset release.
- Per key, on tick: if sync == state, cnt <= 0; else cnt <= cnt+1, and when cnt+1 == DEB_SAMPLES, state <= sync, cnt <= 0. Any bounce back to state before acceptance zeroes cnt.
- Press event: state 0->1 sets pend bit in the same edge that updates state. Release sets nothing.
- Registers (all 32-bit, unused upper bits read 0, writes ignored there):
  - addr 0 STATE: debounced state, read-only.
  - addr 1 PEND: read; write-1-to-clear.
  - addr 2 MASK: read/write, 1 = enables interrupt for that key.
  - addr 3 CTRL: bit0 EN (read/write). EN=0 freezes tick counter, debounce counters and state; pend/mask unaffected.
- irq = |(pend & mask), driven directly from flops.
- Simultaneous set and W1C clear of the same pend bit in one cycle: set wins (bit stays 1).

## Timing
- Reset values: rdata follows addr on zeroed registers; state, pend, mask, cnt, tick counter = 0; EN = 1; irq = 0.
- key_in change to sync: 2 cycles.
- key_in change (held steady, EN=1) to state/pend update: between 2+(DEB_SAMPLES-1)*TICK_DIV+1 and 2+DEB_SAMPLES*TICK_DIV cycles, depending on tick phase.
- pend set to irq high: same cycle pend is visible (0 extra latency).
- Register write takes effect on the write edge; rdata reflects it the following cycle.
- Reset asserted mid-debounce: all counters and state cleared immediately; a key still held after release is re-debounced from zero and produces a fresh press event.

## Structure
- Shared package: register address constants (KEY_STATE=0, KEY_PEND=1, KEY_MASK=2, KEY_CTRL=3), CTRL bit index, default parameter values.
- One sub-module key_debounce (synchroniser + counter + state for a single key, tick and EN as inputs), generated N_KEYS times; tick counter, registers and bus decode in key_ctrl.

## Test plan
(Bench parameters: TICK_DIV=4, DEB_SAMPLES=3.)
- Reset: assert reset mid-run -> all reads 0 except CTRL=1, irq=0; key held through reset yields a press event 11–14 cycles after release.
- Clean press of key 2 (key_in=8'hFB held) -> STATE=0x04 and PEND=0x04 after 11–14 cycles; no earlier change.
- Bounce: key 0 low for 6 cycles, high 2, low held -> only one press event; STATE bit0 set no earlier than 11 cycles after final fall.
- Interrupt: MASK=0x04, press key 2 -> irq=1; press key 5 with MASK bit5=0 -> PEND=0x24, irq stays 1; write PEND=0x04 -> irq=0, PEND=0x20.
- Collision: schedule W1C of bit 2 on the exact edge key 2's press is accepted -> PEND bit2 reads 1 afterwards.
- Freeze: write CTRL=0, press key 7 for 40 cycles -> STATE/PEND unchanged; write CTRL=1 with key still held -> press accepted within 12 cycles.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared constants for the push-button controller: register map, CTRL bits, defaults.
package key_ctrl_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Register word addresses (byte address bits [3:2])
    localparam logic [ADDR_W-1:0] KEY_STATE = 2'd0;
    localparam logic [ADDR_W-1:0] KEY_PEND  = 2'd1;
    localparam logic [ADDR_W-1:0] KEY_MASK  = 2'd2;
    localparam logic [ADDR_W-1:0] KEY_CTRL  = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN_BIT = 0;

    // Default parameter values
    localparam int unsigned N_KEYS_DEF      = 8;
    localparam int unsigned TICK_DIV_DEF    = 50000;
    localparam int unsigned DEB_SAMPLES_DEF = 4;

endpackage

// File: rtl/key_ctrl_debounce.sv
// Single-key synchroniser and tick-sampled debouncer; flags a press on an accepted 0->1.
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    input  logic tick_i,
    input  logic en_i,
    output logic state_o,
    output logic press_c
);

    localparam int unsigned CNT_W = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             sync_c;
    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_c;

    // Two-flop synchroniser; resets to the released level so no phantom press follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign sync_c = ~sync2_q;

    // Count consecutive differing samples; accept the new level after DEB_SAMPLES of them
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        if (tick_i && en_i) begin
            if (sync_c == state_q) begin
                cnt_d = '0;
            end else if (32'(cnt_q) + 32'd1 == 32'(DEB_SAMPLES)) begin
                accept_c = 1'b1;
                state_d  = sync_c;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign press_c = accept_c & sync_c;

endmodule

// File: rtl/key_ctrl.sv
// Push-button controller: shared sample tick, per-key debouncers, pending/mask registers, irq.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int unsigned N_KEYS      = N_KEYS_DEF,
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick_c;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press_c;
    logic [N_KEYS-1:0] pend_q;
    logic [N_KEYS-1:0] pend_d;
    logic [N_KEYS-1:0] mask_q;
    logic [N_KEYS-1:0] mask_d;
    logic              en_q;
    logic              en_d;
    logic              irq_q;
    logic              irq_d;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_wdata_c;

    assign tick_c = en_q && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    // Free-running sample divider, held while EN is low
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (en_q) begin
            tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    // One debouncer per key
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .key_n_i(key_in[k]),
            .tick_i (tick_c),
            .en_i   (en_q),
            .state_o(key_state[k]),
            .press_c(key_press_c[k])
        );
    end

    // Register writes; a press landing with a W1C of the same bit keeps the bit set
    always_comb begin
        pend_d = pend_q;
        mask_d = mask_q;
        en_d   = en_q;
        if (we && (addr == KEY_PEND)) begin
            pend_d = pend_q & ~wdata[N_KEYS-1:0];
        end
        pend_d = pend_d | key_press_c;
        if (we && (addr == KEY_MASK)) begin
            mask_d = wdata[N_KEYS-1:0];
        end
        if (we && (addr == KEY_CTRL)) begin
            en_d = wdata[CTRL_EN_BIT];
        end
        irq_d = |(pend_d & mask_d);
    end

    // Control/status registers; irq registered from next-state so it tracks pend with no lag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            en_q       <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
        end
    end

    // Read mux, zero-extended
    always_comb begin
        rdata_c = '0;
        case (addr)
            KEY_STATE: rdata_c = DATA_W'(key_state);
            KEY_PEND:  rdata_c = DATA_W'(pend_q);
            KEY_MASK:  rdata_c = DATA_W'(mask_q);
            KEY_CTRL:  rdata_c[CTRL_EN_BIT] = en_q;
            default:   rdata_c = '0;
        endcase
    end

    assign unused_wdata_c = ^wdata;
    assign rdata          = rdata_c;
    assign irq            = irq_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_key_ctrl;
    import key_ctrl_pkg::*;

    localparam int NK = 8;
    localparam int TD = 4;
    localparam int DS = 3;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [NK-1:0] key_in = '1;
    logic [1:0]    addr   = 2'd0;
    logic          we     = 1'b0;
    logic [31:0]   wdata  = 32'd0;
    logic [31:0]   rdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    key_ctrl #(
        .N_KEYS     (NK),
        .TICK_DIV   (TD),
        .DEB_SAMPLES(DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_in(key_in),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: keys seen two cycles late, sampled every TD enabled cycles,
    // a level accepted once the last DS samples since the previous change all disagree
    logic [NK-1:0] m_h1, m_h2, m_st, m_pend, m_mask, m_press, m_clr, m_smp;
    logic          m_en, m_irq, m_tk;
    int            m_en_cyc;
    logic [31:0]   m_hist [NK];
    int            m_len  [NK];

    function automatic bit all_eq(input logic [31:0] h, input logic v);
        for (int i = 0; i < DS; i++) begin
            if (h[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit tick_next();
        return m_en && ((m_en_cyc % TD) == TD - 1);
    endfunction

    function automatic bit will_press(input int k);
        logic [31:0] h;
        logic        s;
        if (!tick_next()) return 1'b0;
        s = ~m_h2[k];
        h = {m_hist[k][30:0], s};
        return s && !m_st[k] && (m_len[k] + 1 >= DS) && all_eq(h, 1'b1);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            KEY_STATE: return 32'(m_st);
            KEY_PEND:  return 32'(m_pend);
            KEY_MASK:  return 32'(m_mask);
            default:   return {31'd0, m_en};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_h1 = '1; m_h2 = '1; m_st = '0; m_pend = '0; m_mask = '0;
            m_en = 1'b1; m_irq = 1'b0; m_en_cyc = 0;
            for (int k = 0; k < NK; k++) begin
                m_hist[k] = '0;
                m_len[k]  = 0;
            end
        end else begin
            m_smp   = ~m_h2;
            m_tk    = tick_next();
            m_press = '0;
            if (m_tk) begin
                for (int k = 0; k < NK; k++) begin
                    m_hist[k] = {m_hist[k][30:0], m_smp[k]};
                    m_len[k]++;
                    if (m_len[k] >= DS && all_eq(m_hist[k], ~m_st[k])) begin
                        m_st[k]    = ~m_st[k];
                        m_len[k]   = 0;
                        m_press[k] = m_st[k];
                    end
                end
            end
            if (m_en) m_en_cyc++;
            m_clr  = (we && addr == KEY_PEND) ? wdata[NK-1:0] : '0;
            m_pend = (m_pend & ~m_clr) | m_press;
            if (we && addr == KEY_MASK) m_mask = wdata[NK-1:0];
            if (we && addr == KEY_CTRL) m_en = wdata[0];
            m_irq = |(m_pend & m_mask);
            m_h2  = m_h1;
            m_h1  = key_in;
        end
    end

    // Continuous comparison of the visible outputs against the model
    always @(negedge clk) begin
        check("irq_model", 32'(irq), 32'(m_irq));
        check("rdata_model", rdata, m_read(addr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        @(negedge clk);
        d = rdata;
        step();
    endtask

    // Edges elapsed until the selected bit reads 1; max+1 on timeout
    task automatic wait_bit(input logic [1:0] a, input int b, input int max, output int n);
        addr = a;
        n    = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdata[b] === 1'b1) begin
                n = i;
                break;
            end
        end
        step();
    endtask

    task automatic settle();
        key_in = '1;
        steps(20);
        bus_write(KEY_PEND, 32'hFF);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        bit          hit;

        // Reset values
        steps(3);
        bus_read(KEY_STATE, d); check("rst_state", d, 32'h0);
        bus_read(KEY_PEND,  d); check("rst_pend",  d, 32'h0);
        bus_read(KEY_MASK,  d); check("rst_mask",  d, 32'h0);
        bus_read(KEY_CTRL,  d); check("rst_ctrl",  d, 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        steps(2);

        // Clean press of key 2
        key_in = 8'hFB;
        wait_bit(KEY_STATE, 2, 20, n);
        $display("info: key2 press latency %0d", n);
        check("press_lat_window", 32'(n >= 11 && n <= 14), 32'h1);
        bus_read(KEY_STATE, d); check("press_state", d, 32'h04);
        bus_read(KEY_PEND,  d); check("press_pend",  d, 32'h04);
        settle();

        // Bounce on key 0, aligned so a sample tick lands in the 2-cycle release gap
        for (int i = 0; i < TD && (m_en_cyc % TD) != TD - 1; i++) step();
        key_in = 8'hFE; steps(6);
        key_in = 8'hFF; steps(2);
        key_in = 8'hFE;
        wait_bit(KEY_STATE, 0, 20, n);
        $display("info: bounce accept latency %0d", n);
        check("bounce_lat_window", 32'(n >= 11 && n <= 14), 32'h1);
        bus_read(KEY_PEND, d); check("bounce_pend", d, 32'h01);
        bus_write(KEY_PEND, 32'h01);
        steps(16);
        bus_read(KEY_PEND, d); check("bounce_single_event", d, 32'h00);
        settle();

        // Interrupt masking and acknowledge
        bus_write(KEY_MASK, 32'h04);
        key_in = 8'hFB;
        wait_bit(KEY_PEND, 2, 20, n);
        check("irq_key2_seen", 32'(n <= 14), 32'h1);
        check("irq_key2", 32'(irq), 32'h1);
        key_in = 8'hDB;
        steps(20);
        bus_read(KEY_PEND, d); check("irq_pend_both", d, 32'h24);
        check("irq_still_high", 32'(irq), 32'h1);
        bus_write(KEY_PEND, 32'h04);
        check("irq_after_ack", 32'(irq), 32'h0);
        bus_read(KEY_PEND, d); check("irq_pend_left", d, 32'h20);
        settle();
        bus_write(KEY_MASK, 32'h00);

        // W1C of bit 2 on the very edge key 2 is accepted
        key_in = 8'hFB;
        hit    = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (will_press(2)) begin
                hit = 1'b1;
                bus_write(KEY_PEND, 32'h04);
            end else begin
                step();
            end
        end
        check("collide_reached", 32'(hit), 32'h1);
        bus_read(KEY_PEND, d); check("collide_pend2", 32'(d[2]), 32'h1);
        settle();

        // Freeze with EN=0, then resume
        bus_write(KEY_CTRL, 32'h0);
        key_in = 8'h7F;
        steps(40);
        bus_read(KEY_STATE, d); check("freeze_state", d, 32'h00);
        bus_read(KEY_PEND,  d); check("freeze_pend",  d, 32'h00);
        bus_read(KEY_CTRL,  d); check("freeze_ctrl",  d, 32'h00);
        bus_write(KEY_CTRL, 32'h1);
        wait_bit(KEY_STATE, 7, 20, n);
        $display("info: resume accept latency %0d", n);
        check("resume_lat_window", 32'(n >= 1 && n <= 12), 32'h1);
        bus_read(KEY_PEND, d); check("resume_pend", d, 32'h80);
        settle();

        // Reset mid-run: key 3 pressed and signalled, key 4 mid-debounce, EN cleared
        bus_write(KEY_MASK, 32'h08);
        key_in = 8'hF7;
        steps(16);
        check("pre_rst_irq", 32'(irq), 32'h1);
        key_in = 8'hE7;
        steps(6);
        bus_write(KEY_CTRL, 32'h0);
        reset = 1'b1;
        bus_read(KEY_STATE, d); check("mid_rst_state", d, 32'h0);
        bus_read(KEY_PEND,  d); check("mid_rst_pend",  d, 32'h0);
        bus_read(KEY_MASK,  d); check("mid_rst_mask",  d, 32'h0);
        bus_read(KEY_CTRL,  d); check("mid_rst_ctrl",  d, 32'h1);
        check("mid_rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        wait_bit(KEY_PEND, 3, 20, n);
        $display("info: post-reset press latency %0d", n);
        check("post_rst_lat_window", 32'(n >= 11 && n <= 14), 32'h1);
        bus_read(KEY_PEND, d); check("post_rst_pend", d, 32'h18);
        settle();

        // Random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            we   = 1'b0;
            addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 11) == 0) begin
                we    = 1'b1;
                wdata = $urandom;
                if (addr == KEY_CTRL && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
        end
        we = 1'b0;
        steps(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
